seq_det_multi: RTL and testbench
================================

# seq_det_multi

Parametrised, runtime-programmable Mealy sequence detector: N_CH independent serial bit channels are each checked against one shared programmable pattern of 1..MAX_LEN bits. Overlapping or non-overlapping match mode is selectable at runtime. It succeeds the fixed five-state Mealy detector and sits between the ui_in sampling logic and the uo_out/uio_out pin mux. Outputs are a glitch-free combinational Mealy match, a registered copy, and per-channel saturating match counters.

## Interface
- MAX_LEN, 8: maximum pattern length in bits, 2..16.
- N_CH, 2: number of independent input channels, 1..4.
- CNT_W, 8: width of each per-channel match counter.
- clk  in  1  clock; rst_n synchronous, active-low
- rst_n  in  1  synchronous active-low reset
- cfg_we  in  1  load cfg_* this cycle; clears all channel history
- cfg_pattern  in  MAX_LEN  pattern; bit 0 = newest bit, bit len-1 = oldest
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = restart after match
- in_valid  in  1  in_bits valid this cycle (common strobe for all channels)
- in_bits  in  N_CH  one serial bit per channel
- cnt_clr  in  1  zero all match counters
- match  out  N_CH  Mealy output: in_valid and this bit completes the pattern
- match_q  out  N_CH  match registered once
- match_cnt  out  N_CH*CNT_W  per-channel counts, channel i at [i*CNT_W +: CNT_W]

## Operation
- Config registers: pat (reset 0), len (reset 1), ovl (reset 1). On cfg_we, len = clamp(cfg_len): 0 becomes 1, and values above MAX_LEN become MAX_LEN.
- Per channel state:
  - hist[MAX_LEN-1:0] shift register, reset 0.
  - fill counter 0..len, reset 0, saturates at len.
- Candidate: cand = {hist[MAX_LEN-2:0], bit}. Mask: mask = (1<<len)-1.
- match[i] = in_valid & !cfg_we & (fill+1 >= len) & ((cand & mask) == (pat & mask)). match is purely combinational from registers, in_valid, in_bits and cfg_we. It carries no clock term.
- Channel update on accepted input (in_valid & !cfg_we):
  - hist <= cand.
  - If match and ovl = 0: fill <= 0. History bits are retained but ignored until fill is rebuilt.
  - Otherwise: fill <= min(fill+1, len).
- cfg_we wins over in_valid. That cycle's input is dropped, match is forced 0, and every hist and fill is cleared.
- Counters: on match[i], cnt[i] += 1, saturating at 2^CNT_W-1.
  - cnt_clr zeroes all counters.
  - cnt_clr together with match: the clear wins and the count becomes 0.
  - cfg_we does not clear counters.
- Channels are fully independent. Any subset may match in the same cycle.

## Timing
- Reset (rst_n=0 at clk edge) outputs: match=0, match_q=0, match_cnt=0; pat=0, len=1, ovl=1, all hist/fill=0.
- Reset mid-stream discards partial progress. The first match after reset needs len fresh valid bits.
- match: zero-latency, same cycle as the completing bit.
- match_q and match_cnt: updated at the next clk edge.
- New config applies to the first in_valid cycle after the cfg_we edge.
- Idle cycles (in_valid=0) hold all state. Gaps within a pattern are allowed.
- len=1: every valid bit equal to pat[0] matches. Non-overlap mode behaves the same.
- len=MAX_LEN: the full hist is compared. The oldest bit shifts out with no wrap.

## Structure
- Package seq_det_pkg holds:
  - MAX_LEN_LIMIT=16 and CNT_W default.
  - Function len_w(max) returning $clog2(max+1).
  - Function clamp_len.
- Sub-module seq_det_channel: hist, fill, match compare and saturating counter for one channel, instantiated N_CH times via generate.
- The top module holds the config registers and the match_q register, and drives the shared pat/mask/len.

## Test plan
- Reset, then program pat=8'b0000_1101, len=4, ovl=1. Feed ch0 bits 1,1,0,1,1,0,1 (oldest first). Required: match[0] high on the 4th and 7th valid bits (overlap), match_q[0] one cycle later each time, cnt0=2.
- Same stream with ovl=0. Required: match only on the 4th bit, cnt0=1.
- N_CH=2: ch0 carries the pattern and ch1 its complement. Required: only match[0] fires, cnt1=0. Then feed both the pattern and check simultaneous match=2'b11.
- Pattern 1101 fed as 1,1,in_valid=0 for 3 cycles,0,1. Required: match on the final bit; no change during the gap.
- cfg_we asserted with in_valid on the cycle that would complete the pattern. Required: match=0, bit dropped, history cleared; cfg_len=0 loads as len=1. cfg_len=12 with MAX_LEN=8 loads len=8.
- 300 matches with len=1, pat[0]=1. Required: cnt saturates at 255. Then cnt_clr together with a match gives cnt=0. rst_n low mid-pattern: the next match needs 4 new bits.

Source files
------------

// File: rtl/seq_det_multi_pkg.sv
// seq_det_pkg: shared constants and helpers for the multi-channel sequence detector.
//   MAX_LEN_LIMIT : largest supported pattern length
//   CNT_W_DEF     : default per-channel match counter width
//   len_w()       : width needed to hold a length value 0..max
//   clamp_len()   : folds a programmed length into the legal range 1..max
package seq_det_pkg;

    localparam int unsigned MAX_LEN_LIMIT = 16;
    localparam int unsigned CNT_W_DEF     = 8;

    function automatic int unsigned len_w(input int unsigned max);
        return $clog2(max + 1);
    endfunction

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max);
        if (len == 0)
            return 1;
        if (len > max)
            return max;
        return len;
    endfunction

endpackage

// File: rtl/seq_det_multi_if.sv
// seq_det_multi_if: configuration, serial input and match result bundle.
//   master : drives cfg_*, in_valid, in_bits, cnt_clr; observes match outputs
//   slave  : the detector side
//   match_cnt packs channel i at [i*CNT_W +: CNT_W]
interface seq_det_multi_if
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned N_CH    = 2,
    parameter int unsigned CNT_W   = CNT_W_DEF
);
    localparam int unsigned LW = len_w(MAX_LEN);

    logic                    cfg_we;
    logic [MAX_LEN-1:0]      cfg_pattern;
    logic [LW-1:0]           cfg_len;
    logic                    cfg_overlap;
    logic                    in_valid;
    logic [N_CH-1:0]         in_bits;
    logic                    cnt_clr;
    logic [N_CH-1:0]         match;
    logic [N_CH-1:0]         match_q;
    logic [N_CH*CNT_W-1:0]   match_cnt;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bits, cnt_clr,
        input  match, match_q, match_cnt
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bits, cnt_clr,
        output match, match_q, match_cnt
    );

endinterface

// File: rtl/seq_det_multi_channel.sv
// seq_det_channel: one serial channel of the detector.
//   clk, rst_n    : clock, synchronous active-low reset
//   cfg_we        : config load; drops this cycle's bit and clears history
//   in_valid      : in_bit is valid this cycle
//   in_bit        : serial input bit
//   cnt_clr       : zero the match counter (wins over an increment)
//   ovl           : 1 = overlapping matches, 0 = restart after a match
//   pat, mask, len: shared pattern, active-bit mask and length
//   match         : combinational Mealy match for this bit
//   cnt           : saturating match count
module seq_det_channel
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned LW      = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cnt_clr,
    input  logic               ovl,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [MAX_LEN-1:0] mask,
    input  logic [LW-1:0]      len,
    output logic               match,
    output logic [CNT_W-1:0]   cnt
);
    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] cand;
    logic [LW-1:0]      fill;
    logic [LW:0]        fill_inc;
    logic               accept;

    assign cand     = {hist[MAX_LEN-2:0], in_bit};
    assign fill_inc = {1'b0, fill} + (LW+1)'(1);
    // rst_n gates acceptance so match stays low throughout reset
    assign accept   = rst_n & in_valid & ~cfg_we;
    assign match    = accept & (fill_inc >= {1'b0, len}) & ((cand & mask) == (pat & mask));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist <= '0;
            fill <= '0;
        end else if (cfg_we) begin
            hist <= '0;
            fill <= '0;
        end else if (in_valid) begin
            hist <= cand;
            if (match && !ovl)
                fill <= '0;
            else if (fill_inc > {1'b0, len})
                fill <= len;
            else
                fill <= fill_inc[LW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr)
            cnt <= '0;
        else if (match && (cnt != '1))
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/seq_det_multi.sv
// seq_det_multi: N_CH-channel programmable Mealy sequence detector.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : seq_det_multi_if.slave carrying config, serial inputs,
//                combinational match, registered match_q and packed match_cnt
// Holds the shared pattern/length/overlap config and the match_q register.
module seq_det_multi
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned N_CH    = 2,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_det_multi_if.slave bus
);
    localparam int unsigned LW = len_w(MAX_LEN);

    logic [MAX_LEN-1:0]    pat;
    logic [MAX_LEN-1:0]    mask;
    logic [LW-1:0]         len;
    logic                  ovl;
    logic [N_CH-1:0]       match;
    logic [N_CH-1:0]       match_q;
    logic [N_CH*CNT_W-1:0] cnt_flat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat <= '0;
            len <= LW'(1);
            ovl <= 1'b1;
        end else if (bus.cfg_we) begin
            pat <= bus.cfg_pattern;
            len <= LW'(clamp_len(32'(bus.cfg_len), MAX_LEN));
            ovl <= bus.cfg_overlap;
        end
    end

    // Thermometer mask avoids a shift that would overflow at len == MAX_LEN
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++)
            mask[i] = (i < 32'(len));
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        seq_det_channel #(
            .MAX_LEN (MAX_LEN),
            .CNT_W   (CNT_W),
            .LW      (LW)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .cfg_we   (bus.cfg_we),
            .in_valid (bus.in_valid),
            .in_bit   (bus.in_bits[i]),
            .cnt_clr  (bus.cnt_clr),
            .ovl      (ovl),
            .pat      (pat),
            .mask     (mask),
            .len      (len),
            .match    (match[i]),
            .cnt      (cnt_flat[i*CNT_W +: CNT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            match_q <= '0;
        else
            match_q <= match;
    end

    assign bus.match     = match;
    assign bus.match_q   = match_q;
    assign bus.match_cnt = cnt_flat;

endmodule

// File: tb/tb_seq_det_multi.sv
// tb_seq_det_multi: directed scoreboard bench for seq_det_multi (MAX_LEN=8, N_CH=2, CNT_W=8).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_seq_det_multi;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic started = 1'b0;
    logic chk_cnt = 1'b0;
    logic [1:0] prev_exp = 2'b00;

    logic [1:0]  exp_m[$];
    logic [15:0] exp_c[$];

    int errors = 0;
    int checks = 0;

    seq_det_multi_if #(.MAX_LEN(8), .N_CH(2), .CNT_W(8)) bus ();

    seq_det_multi #(.MAX_LEN(8), .N_CH(2), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Monitor
    always @(negedge clk) begin
        if (started) begin
            logic [1:0]  e;
            logic [15:0] c;
            checks++;
            if (bus.match_q !== prev_exp) begin
                errors++;
                $display("FAIL match_q: got %b expected %b", bus.match_q, prev_exp);
            end
            if (bus.in_valid) begin
                checks++;
                if (exp_m.size() == 0) begin
                    errors++;
                    $display("FAIL match_sb: got match %b expected no valid input queued", bus.match);
                    e = 2'b00;
                end else begin
                    e = exp_m.pop_front();
                    if (bus.match !== e) begin
                        errors++;
                        $display("FAIL match: got %b expected %b", bus.match, e);
                    end
                end
            end else begin
                e = 2'b00;
                checks++;
                if (bus.match !== 2'b00) begin
                    errors++;
                    $display("FAIL match_idle: got %b expected 00", bus.match);
                end
            end
            prev_exp <= rst_n ? e : 2'b00;
            if (chk_cnt) begin
                checks++;
                if (exp_c.size() == 0) begin
                    errors++;
                    $display("FAIL cnt_sb: got %h expected queued count", bus.match_cnt);
                end else begin
                    c = exp_c.pop_front();
                    if (bus.match_cnt !== c) begin
                        errors++;
                        $display("FAIL match_cnt: got cnt1=%0d cnt0=%0d expected cnt1=%0d cnt0=%0d",
                                 bus.match_cnt[15:8], bus.match_cnt[7:0], c[15:8], c[7:0]);
                    end
                end
            end
        end
    end

    task automatic step(input logic v, input logic [1:0] b, input logic [1:0] e);
        bus.in_valid = v;
        bus.in_bits  = b;
        if (v) exp_m.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_bits  = 2'b00;
    endtask

    // Literals read left-to-right oldest-first: bit n-1 is sent first
    task automatic run(input int n, input logic [31:0] c0, input logic [31:0] c1,
                       input logic [31:0] m0, input logic [31:0] m1);
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = n - 1 - k;
            step(1'b1, {c1[idx], c0[idx]}, {m1[idx], m0[idx]});
        end
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o,
                       input logic v, input logic [1:0] b);
        bus.cfg_we      = 1'b1;
        bus.cfg_pattern = p;
        bus.cfg_len     = l;
        bus.cfg_overlap = o;
        bus.in_valid    = v;
        bus.in_bits     = b;
        if (v) exp_m.push_back(2'b00);
        @(posedge clk); #1;
        bus.cfg_we   = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_bits  = 2'b00;
    endtask

    task automatic chk(input logic [7:0] c0, input logic [7:0] c1);
        exp_c.push_back({c1, c0});
        chk_cnt = 1'b1;
        @(posedge clk); #1;
        chk_cnt = 1'b0;
    endtask

    initial begin
        bus.cfg_we = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0;
        bus.in_valid = 1'b0; bus.in_bits = '0; bus.cnt_clr = 1'b0;

        @(posedge clk); #1;
        started = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset state: counters zero, config pat=0 len=1
        chk(8'd0, 8'd0);
        step(1'b1, 2'b10, 2'b01);

        // Overlap, pattern 1101
        cfg(8'b0000_1101, 4'd4, 1'b1, 1'b0, 2'b00);
        run(7, 32'b1101101, 32'b0, 32'b0001001, 32'b0);
        chk(8'd3, 8'd0);

        // Non-overlap, same stream; cfg_we keeps counters
        cfg(8'b0000_1101, 4'd4, 1'b0, 1'b0, 2'b00);
        run(7, 32'b1101101, 32'b0, 32'b0001000, 32'b0);
        chk(8'd4, 8'd0);

        // ch1 complement, then both channels match together
        cfg(8'b0000_1101, 4'd4, 1'b1, 1'b0, 2'b00);
        run(4, 32'b1101, 32'b0010, 32'b0001, 32'b0000);
        chk(8'd5, 8'd0);
        run(4, 32'b1101, 32'b1101, 32'b0001, 32'b0001);
        chk(8'd6, 8'd1);

        // Gap inside the pattern
        cfg(8'b0000_1101, 4'd4, 1'b1, 1'b0, 2'b00);
        run(2, 32'b11, 32'b0, 32'b0, 32'b0);
        step(1'b0, 2'b01, 2'b00);
        chk(8'd6, 8'd1);
        step(1'b0, 2'b00, 2'b00);
        run(2, 32'b01, 32'b0, 32'b01, 32'b0);
        chk(8'd7, 8'd1);

        // cfg_we on the completing bit: dropped, history cleared
        cfg(8'b0000_1101, 4'd4, 1'b1, 1'b0, 2'b00);
        run(3, 32'b110, 32'b0, 32'b0, 32'b0);
        cfg(8'b0000_1101, 4'd4, 1'b1, 1'b1, 2'b01);
        run(3, 32'b101, 32'b0, 32'b0, 32'b0);

        // cfg_len=0 loads as len=1
        cfg(8'b0000_0001, 4'd0, 1'b0, 1'b0, 2'b00);
        run(3, 32'b101, 32'b0, 32'b101, 32'b0);
        chk(8'd9, 8'd1);

        // cfg_len=12 clamps to 8; oldest bit shifts out
        cfg(8'b1010_0101, 4'd12, 1'b1, 1'b0, 2'b00);
        run(9, 32'b110100101, 32'b0, 32'b000000001, 32'b0);
        chk(8'd10, 8'd1);

        // Saturation with len=1, ch1 alternates
        cfg(8'b0000_0001, 4'd1, 1'b1, 1'b0, 2'b00);
        for (int k = 0; k < 300; k++) begin
            logic b1;
            b1 = (k % 2) == 1;
            step(1'b1, {b1, 1'b1}, {b1, 1'b1});
        end
        chk(8'd255, 8'd151);

        // cnt_clr beats a simultaneous match
        bus.cnt_clr = 1'b1;
        step(1'b1, 2'b11, 2'b11);
        bus.cnt_clr = 1'b0;
        chk(8'd0, 8'd0);

        // Reset mid-pattern
        cfg(8'b0000_1101, 4'd4, 1'b1, 1'b0, 2'b00);
        run(3, 32'b110, 32'b0, 32'b0, 32'b0);
        rst_n = 1'b0;
        step(1'b0, 2'b00, 2'b00);
        rst_n = 1'b1;
        chk(8'd0, 8'd0);
        step(1'b1, 2'b00, 2'b11);
        step(1'b1, 2'b01, 2'b10);
        cfg(8'b0000_1101, 4'd4, 1'b1, 1'b0, 2'b00);
        run(4, 32'b1101, 32'b0, 32'b0001, 32'b0);
        chk(8'd2, 8'd2);

        for (int k = 0; k < 20 && (exp_m.size() != 0 || exp_c.size() != 0); k++)
            @(posedge clk);
        checks++;
        if (exp_m.size() != 0 || exp_c.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", exp_m.size(), exp_c.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
